// File: rtl/usb_ext_pkg.sv
// rtl/usb_ext_pkg.sv - shared states, default timing and bus idle levels for the USB external-bus master
package usb_ext_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_GAP
  } state_t;

  localparam int DEF_ALE_CYCLES    = 2;
  localparam int DEF_SETUP_CYCLES  = 1;
  localparam int DEF_STROBE_CYCLES = 2;
  localparam int DEF_HOLD_CYCLES   = 1;
  localparam int DEF_CNT_W         = 4;

  localparam logic ALEN_IDLE = 1'b1;
  localparam logic CEN_IDLE  = 1'b1;
  localparam logic RDN_IDLE  = 1'b1;
  localparam logic WRN_IDLE  = 1'b1;

endpackage

// File: rtl/usb_ext_phase_timer.sv
// rtl/usb_ext_phase_timer.sv - loadable down-counter timing every bus phase
module usb_ext_phase_timer #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  // Loading N-1 on phase entry makes done true in the phase's last cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/usb_ext_master.sv
// rtl/usb_ext_master.sv - single-beat request to timed ALEn/CEn/RDn/WRn bus cycle initiator
module usb_ext_master
  import usb_ext_pkg::*;
#(
  parameter int ALE_CYCLES    = DEF_ALE_CYCLES,
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int STROBE_CYCLES = DEF_STROBE_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [7:0] req_addr,
  input  logic [7:0] req_wdata,
  input  logic       req_force_ale,
  output logic       rsp_valid,
  output logic       rsp_write,
  output logic [7:0] rsp_rdata,
  output logic       busy,
  output logic [7:0] usb_addr_o,
  output logic [7:0] usb_d_o,
  output logic       usb_d_oe,
  input  logic [7:0] usb_d_i,
  output logic       usb_alen_o,
  output logic       usb_cen_o,
  output logic       usb_rdn_o,
  output logic       usb_wrn_o
);

  localparam logic [CNT_W-1:0] ALE_LD    = CNT_W'(ALE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  logic             wr_q;
  logic [7:0]       wdata_q;
  logic [7:0]       last_addr;
  logic             addr_valid;
  logic             accept;
  logic             need_ale;
  logic             t_load;
  logic [CNT_W-1:0] t_val;
  logic             t_done;

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign accept    = req_valid & req_ready;
  assign need_ale  = !addr_valid || req_force_ale || (req_addr != last_addr);

  always_comb begin
    t_load = 1'b0;
    t_val  = '0;
    case (state)
      ST_IDLE: if (accept) begin
        t_load = 1'b1;
        t_val  = need_ale ? ALE_LD : SETUP_LD;
      end
      ST_ALE:    if (t_done) begin t_load = 1'b1; t_val = SETUP_LD;  end
      ST_SETUP:  if (t_done) begin t_load = 1'b1; t_val = STROBE_LD; end
      ST_STROBE: if (t_done) begin t_load = 1'b1; t_val = HOLD_LD;   end
      default: ;
    endcase
  end

  usb_ext_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  // Outputs are set on the edge entering each phase so the bus sees clean registered levels.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      wr_q       <= 1'b0;
      wdata_q    <= '0;
      last_addr  <= '0;
      addr_valid <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_write  <= 1'b0;
      rsp_rdata  <= '0;
      usb_addr_o <= '0;
      usb_d_o    <= '0;
      usb_d_oe   <= 1'b0;
      usb_alen_o <= ALEN_IDLE;
      usb_cen_o  <= CEN_IDLE;
      usb_rdn_o  <= RDN_IDLE;
      usb_wrn_o  <= WRN_IDLE;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: if (accept) begin
          wr_q    <= req_write;
          wdata_q <= req_wdata;
          if (need_ale) begin
            state      <= ST_ALE;
            usb_addr_o <= req_addr;
            usb_alen_o <= 1'b0;
          end else begin
            state     <= ST_SETUP;
            usb_cen_o <= 1'b0;
            usb_d_oe  <= req_write;
            usb_d_o   <= req_wdata;
          end
        end
        ST_ALE: if (t_done) begin
          state      <= ST_SETUP;
          usb_alen_o <= ALEN_IDLE;
          last_addr  <= usb_addr_o;
          addr_valid <= 1'b1;
          usb_cen_o  <= 1'b0;
          usb_d_oe   <= wr_q;
          usb_d_o    <= wdata_q;
        end
        ST_SETUP: if (t_done) begin
          state <= ST_STROBE;
          if (wr_q) usb_wrn_o <= 1'b0;
          else      usb_rdn_o <= 1'b0;
        end
        ST_STROBE: if (t_done) begin
          state     <= ST_HOLD;
          usb_wrn_o <= WRN_IDLE;
          usb_rdn_o <= RDN_IDLE;
          if (!wr_q) rsp_rdata <= usb_d_i;
        end
        ST_HOLD: if (t_done) begin
          state     <= ST_GAP;
          usb_cen_o <= CEN_IDLE;
          usb_d_oe  <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_write <= wr_q;
        end
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_ext_master.sv
// tb/tb_usb_ext_master.sv - directed bench with an interval-based bus timing model for usb_ext_master
module tb_usb_ext_master;

  logic       clk;
  logic       reset_n;
  logic       req_valid [2];
  logic       req_ready [2];
  logic       req_write [2];
  logic [7:0] req_addr [2];
  logic [7:0] req_wdata [2];
  logic       req_force_ale [2];
  logic       rsp_valid [2];
  logic       rsp_write [2];
  logic [7:0] rsp_rdata [2];
  logic       busy [2];
  logic [7:0] usb_addr [2];
  logic [7:0] usb_d_o [2];
  logic       usb_d_oe [2];
  logic [7:0] usb_d_i [2];
  logic       usb_alen [2];
  logic       usb_cen [2];
  logic       usb_rdn [2];
  logic       usb_wrn [2];
  logic [7:0] rd_val [2];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  // Phase lengths of each instance: A, S, W, H
  int pa [2] = '{2, 2};
  int ps [2] = '{1, 1};
  int pw [2] = '{2, 5};
  int ph [2] = '{1, 3};

  // Model of the transaction in flight per instance
  int         t0 [2] = '{-1000, -1000};
  bit         m_ale [2] = '{0, 0};
  bit         m_wr [2] = '{0, 0};
  logic [7:0] m_wdata [2] = '{8'h00, 8'h00};
  logic [7:0] m_last [2] = '{8'h00, 8'h00};
  bit         m_av [2] = '{0, 0};
  logic [7:0] e_addr [2] = '{8'h00, 8'h00};
  logic [7:0] e_rdata [2] = '{8'h00, 8'h00};

  usb_ext_master dut0 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_force_ale(req_force_ale[0]),
    .rsp_valid(rsp_valid[0]), .rsp_write(rsp_write[0]), .rsp_rdata(rsp_rdata[0]),
    .busy(busy[0]), .usb_addr_o(usb_addr[0]), .usb_d_o(usb_d_o[0]), .usb_d_oe(usb_d_oe[0]),
    .usb_d_i(usb_d_i[0]), .usb_alen_o(usb_alen[0]), .usb_cen_o(usb_cen[0]),
    .usb_rdn_o(usb_rdn[0]), .usb_wrn_o(usb_wrn[0])
  );

  usb_ext_master #(.STROBE_CYCLES(5), .HOLD_CYCLES(3)) dut1 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_force_ale(req_force_ale[1]),
    .rsp_valid(rsp_valid[1]), .rsp_write(rsp_write[1]), .rsp_rdata(rsp_rdata[1]),
    .busy(busy[1]), .usb_addr_o(usb_addr[1]), .usb_d_o(usb_d_o[1]), .usb_d_oe(usb_d_oe[1]),
    .usb_d_i(usb_d_i[1]), .usb_alen_o(usb_alen[1]), .usb_cen_o(usb_cen[1]),
    .usb_rdn_o(usb_rdn[1]), .usb_wrn_o(usb_wrn[1])
  );

  // The responder only drives meaningful data while RDn is low.
  assign usb_d_i[0] = usb_rdn[0] ? 8'hEE : rd_val[0];
  assign usb_d_i[1] = usb_rdn[1] ? 8'hEE : rd_val[1];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
  endtask

  // Model + compare: each output is judged by which phase interval cycle k falls into.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int l, k, en;
      bit stb, e_cen;
      if (!reset_n) begin
        t0[d] = -1000; m_av[d] = 0; e_addr[d] = 8'h00; e_rdata[d] = 8'h00;
      end
      l     = m_ale[d] ? pa[d] : 0;
      k     = cyc - t0[d];
      en    = l + ps[d] + pw[d] + ph[d] + 1;
      stb   = (k >= l + ps[d] + 1) && (k <= l + ps[d] + pw[d]);
      e_cen = !((k >= l + 1) && (k <= l + ps[d] + pw[d] + ph[d]));
      chk($sformatf("d%0d req_ready", d), req_ready[d], !((k >= 1) && (k <= en)));
      chk($sformatf("d%0d alen", d), usb_alen[d], !((k >= 1) && (k <= l)));
      chk($sformatf("d%0d cen", d), usb_cen[d], e_cen);
      chk($sformatf("d%0d wrn", d), usb_wrn[d], !(stb && m_wr[d]));
      chk($sformatf("d%0d rdn", d), usb_rdn[d], !(stb && !m_wr[d]));
      chk($sformatf("d%0d d_oe", d), usb_d_oe[d], m_wr[d] && !e_cen);
      chk($sformatf("d%0d rsp_valid", d), rsp_valid[d], k == en);
      chk($sformatf("d%0d rsp_rdata", d), rsp_rdata[d], e_rdata[d]);
      chk($sformatf("d%0d addr", d), usb_addr[d], e_addr[d]);
      if (m_wr[d] && !e_cen) chk($sformatf("d%0d d_o", d), usb_d_o[d], m_wdata[d]);
      if (k == en) chk($sformatf("d%0d rsp_write", d), rsp_write[d], m_wr[d]);
      if (reset_n) begin
        if (!m_wr[d] && k == l + ps[d] + pw[d]) e_rdata[d] = usb_d_i[d];
        if ((k < 1 || k > en) && req_valid[d]) begin
          t0[d]      = cyc;
          m_wr[d]    = req_write[d];
          m_wdata[d] = req_wdata[d];
          m_ale[d]   = !m_av[d] || req_force_ale[d] || (req_addr[d] != m_last[d]);
          if (m_ale[d]) e_addr[d] = req_addr[d];
          m_av[d]    = 1;
          m_last[d]  = req_addr[d];
        end
      end
    end
  end

  task automatic issue(input int d, input bit wr, input logic [7:0] a, input logic [7:0] wd,
                       input bit f, input logic [7:0] rv, output int lat, output int an,
                       output int sn, output int cn, output logic [7:0] rd);
    lat = -1; an = 0; sn = 0; cn = 0; rd = 8'h00;
    @(posedge clk); #2;
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = a;
    req_wdata[d] = wd; req_force_ale[d] = f; rd_val[d] = rv;
    @(posedge clk); #2;
    // Scramble the request fields: only the accept cycle may matter.
    req_valid[d] = 1'b0; req_write[d] = !wr; req_addr[d] = ~a;
    req_wdata[d] = ~wd; req_force_ale[d] = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (!usb_alen[d]) an++;
      if (!usb_cen[d]) cn++;
      if (!usb_rdn[d] || !usb_wrn[d]) sn++;
      if (rsp_valid[d]) begin
        lat = n;
        rd  = rsp_rdata[d];
        break;
      end
    end
    if (lat < 0) chk("rsp timeout", 0, 1);
  endtask

  initial begin
    int lat, an, sn, cn, found;
    logic [7:0] rd;
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 0; req_write[d] = 0; req_addr[d] = 0;
      req_wdata[d] = 0; req_force_ale[d] = 0; rd_val[d] = 0;
    end
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    #1;
    chk("reset ready", req_ready[0], 1);
    chk("reset alen", usb_alen[0], 1);
    chk("reset addr", usb_addr[0], 0);
    chk("reset d_o", usb_d_o[0], 0);
    chk("reset rsp_write", rsp_write[0], 0);

    issue(0, 1, 8'h05, 8'hA3, 0, 8'h00, lat, an, sn, cn, rd);
    chk("wr05 latency", lat, 7);
    chk("wr05 ale cycles", an, 2);
    chk("wr05 wrn cycles", sn, 2);
    chk("wr05 cen cycles", cn, 4);

    issue(0, 0, 8'h05, 8'h00, 0, 8'h5C, lat, an, sn, cn, rd);
    chk("rd05 latency", lat, 5);
    chk("rd05 ale cycles", an, 0);
    chk("rd05 rdn cycles", sn, 2);
    chk("rd05 rdata", rd, 8'h5C);

    for (int i = 0; i < 4; i++) begin
      issue(0, 0, (i == 3) ? 8'h04 : 8'h03, 8'h00, 0, vals[i], lat, an, sn, cn, rd);
      chk($sformatf("burst%0d latency", i), lat, (i == 0 || i == 3) ? 7 : 5);
      chk($sformatf("burst%0d ale cycles", i), an, (i == 0 || i == 3) ? 2 : 0);
      chk($sformatf("burst%0d rdata", i), rd, vals[i]);
    end

    issue(0, 0, 8'h04, 8'h00, 1, 8'h66, lat, an, sn, cn, rd);
    chk("force latency", lat, 7);
    chk("force ale cycles", an, 2);

    issue(1, 0, 8'h10, 8'h00, 0, 8'hA5, lat, an, sn, cn, rd);
    chk("long latency", lat, 12);
    chk("long rdn cycles", sn, 5);
    chk("long cen cycles", cn, 9);
    chk("long rdata", rd, 8'hA5);

    // Reset in the middle of a write strobe
    @(posedge clk); #2;
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 8'h04; req_wdata[0] = 8'h7E;
    @(posedge clk); #2;
    req_valid[0] = 1'b0;
    found = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!usb_wrn[0]) begin found = 1; break; end
    end
    chk("strobe before reset", found, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("async wrn", usb_wrn[0], 1);
    chk("async cen", usb_cen[0], 1);
    chk("async alen", usb_alen[0], 1);
    chk("async d_oe", usb_d_oe[0], 0);
    chk("async busy", busy[0], 0);
    @(posedge clk); @(posedge clk); #2;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);

    issue(0, 1, 8'h04, 8'h7E, 0, 8'h00, lat, an, sn, cn, rd);
    chk("post-reset latency", lat, 7);
    chk("post-reset ale cycles", an, 2);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
